// File: rtl/kyber_pkg.sv
// kyber_pkg: shared Kyber constants and the ntt_ctrl state encoding.
//   N          polynomial length (coefficients)
//   LOG_N      address width of the coefficient RAM
//   NTT_LAYERS butterfly layers in one full NTT / inverse NTT
//   KYBER_Q    modulus, kept here for the butterfly unit
package kyber_pkg;

    localparam int N          = 256;
    localparam int LOG_N      = 8;
    localparam int NTT_LAYERS = 7;
    localparam int KYBER_Q    = 3329;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_GAP,
        ST_DRAIN,
        ST_DONE
    } ntt_state_t;

endpackage

// File: rtl/ntt_ctrl_if.sv
// ntt_ctrl_if: control/address bundle between the NTT sequencer and its host,
// coefficient RAM and butterfly unit.
//   start, inv           host -> sequencer (pass request, direction)
//   busy, done, ct       sequencer status and butterfly mode
//   rd_valid, rd_addr_a, rd_addr_b, tw_addr   read side of one butterfly
//   wr_valid, wr_addr_a, wr_addr_b            aligned write-back strobe
// master = host side, slave = ntt_ctrl.
interface ntt_ctrl_if;

    logic       start;
    logic       inv;
    logic       busy;
    logic       done;
    logic       ct;
    logic       rd_valid;
    logic [7:0] rd_addr_a;
    logic [7:0] rd_addr_b;
    logic [6:0] tw_addr;
    logic       wr_valid;
    logic [7:0] wr_addr_a;
    logic [7:0] wr_addr_b;

    modport master (
        output start, inv,
        input  busy, done, ct, rd_valid, rd_addr_a, rd_addr_b, tw_addr,
               wr_valid, wr_addr_a, wr_addr_b
    );

    modport slave (
        input  start, inv,
        output busy, done, ct, rd_valid, rd_addr_a, rd_addr_b, tw_addr,
               wr_valid, wr_addr_a, wr_addr_b
    );

endinterface

// File: rtl/ntt_wb_delay.sv
// ntt_wb_delay: PIPE_LAT-stage shift register that turns the registered read
// issue {rd_valid, rd_addr_a, rd_addr_b} into the write-back strobe
// {wr_valid, wr_addr_a, wr_addr_b}. Reset clears every stage so writes still
// in flight are dropped.
//   clk, rst  clock, asynchronous active-high reset
//   din       stage-0 input
//   dout      output of the last stage (PIPE_LAT cycles after din)
module ntt_wb_delay #(
    parameter int PIPE_LAT = 8,
    parameter int WIDTH    = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [PIPE_LAT-1:0][WIDTH-1:0] stage_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q[0] <= din;
            for (int i = 1; i < PIPE_LAT; i++)
                stage_q[i] <= stage_q[i-1];
        end
    end

    assign dout = stage_q[PIPE_LAT-1];

endmodule

// File: rtl/ntt_ctrl.sv
// ntt_ctrl: sequencer for one 256-point Kyber NTT (CT) or inverse NTT (GS)
// pass. Walks 7 layers x 128 butterflies, one per cycle, with a PIPE_LAT
// idle gap between layers so the previous layer's write-backs have landed
// before the next layer reads.
//   clk, rst  clock, asynchronous active-high reset
//   bus       ntt_ctrl_if.slave: start/inv in; busy, done, ct, read
//             addresses + twiddle index, delayed write-back addresses out
// All outputs are registered; outputs lag the FSM state by one cycle.
module ntt_ctrl
    import kyber_pkg::*;
#(
    parameter int PIPE_LAT = 8
) (
    input  logic        clk,
    input  logic        rst,
    ntt_ctrl_if.slave   bus
);

    localparam int         WB_W     = 1 + 2*LOG_N;
    localparam logic [4:0] CNT_LAST = 5'(PIPE_LAT - 1);
    localparam logic [2:0] LAST_LYR = 3'(NTT_LAYERS - 1);

    ntt_state_t state_q, state_d;
    logic [2:0] layer_q, layer_d;
    logic [6:0] idx_q,   idx_d;
    logic [4:0] cnt_q,   cnt_d;
    logic       inv_q,   inv_d;

    logic       busy_q,  busy_d;
    logic       done_q,  done_d;
    logic       ct_q,    ct_d;
    logic       rdv_q,   rdv_d;
    logic [7:0] a_q,     a_d;
    logic [7:0] b_q,     b_d;
    logic [6:0] tw_q,    tw_d;

    // Butterfly address for (layer, idx): idx splits into a group number
    // (upper bits) and an offset inside the group (lower lg bits); groups are
    // 2*len apart. Forward layers shrink len from 128, inverse grow it from 2.
    logic [2:0] lg;
    logic [3:0] lg1;
    logic [7:0] idx8, len, grp, j;
    logic [6:0] tw_calc;

    always_comb begin
        idx8 = {1'b0, idx_q};
        lg   = inv_q ? layer_q + 3'd1 : 3'd7 - layer_q;
        lg1  = {1'b0, lg} + 4'd1;
        len  = 8'd1 << lg;
        grp  = idx8 >> lg;
        j    = (grp << lg1) | (idx8 & (len - 8'd1));
        // (128 >> layer) - 1 equals 7'h7f >> layer, which keeps this 7-bit.
        tw_calc = inv_q ? (7'h7f >> layer_q) - grp[6:0]
                        : (7'd1  << layer_q) + grp[6:0];
    end

    always_comb begin
        state_d = state_q;
        layer_d = layer_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        inv_d   = inv_q;
        ct_d    = ct_q;
        rdv_d   = 1'b0;
        a_d     = '0;
        b_d     = '0;
        tw_d    = '0;
        done_d  = 1'b0;
        busy_d  = (state_q == ST_RUN) || (state_q == ST_GAP) ||
                  (state_q == ST_DRAIN);

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    inv_d   = bus.inv;
                    ct_d    = ~bus.inv;
                    layer_d = '0;
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                rdv_d = 1'b1;
                a_d   = j;
                b_d   = j + len;
                tw_d  = tw_calc;
                idx_d = idx_q + 7'd1;
                cnt_d = '0;
                if (idx_q == 7'd127)
                    state_d = (layer_q == LAST_LYR) ? ST_DRAIN : ST_GAP;
            end
            ST_GAP: begin
                if (cnt_q == CNT_LAST) begin
                    layer_d = layer_q + 3'd1;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            ST_DRAIN: begin
                // Wait out the write-back pipe so done follows the last write.
                if (cnt_q == CNT_LAST)
                    state_d = ST_DONE;
                else
                    cnt_d = cnt_q + 5'd1;
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            layer_q <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            inv_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ct_q    <= 1'b0;
            rdv_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            tw_q    <= '0;
        end else begin
            state_q <= state_d;
            layer_q <= layer_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            inv_q   <= inv_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ct_q    <= ct_d;
            rdv_q   <= rdv_d;
            a_q     <= a_d;
            b_q     <= b_d;
            tw_q    <= tw_d;
        end
    end

    logic [WB_W-1:0] wb_out;

    ntt_wb_delay #(
        .PIPE_LAT (PIPE_LAT),
        .WIDTH    (WB_W)
    ) u_wb_delay (
        .clk  (clk),
        .rst  (rst),
        .din  ({rdv_q, a_q, b_q}),
        .dout (wb_out)
    );

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.ct        = ct_q;
    assign bus.rd_valid  = rdv_q;
    assign bus.rd_addr_a = a_q;
    assign bus.rd_addr_b = b_q;
    assign bus.tw_addr   = tw_q;
    assign bus.wr_valid  = wb_out[WB_W-1];
    assign bus.wr_addr_a = wb_out[2*LOG_N-1:LOG_N];
    assign bus.wr_addr_b = wb_out[LOG_N-1:0];

endmodule

// File: tb/tb_ntt_ctrl.sv
// tb_ntt_ctrl: scoreboard bench for ntt_ctrl. Each start pushes the whole
// expected pass (issue cycle, addresses, twiddle, mode; write cycle and
// addresses; done cycle) built from the textbook Kyber NTT loop nest; a
// negedge monitor pops and compares whenever the DUT presents rd/wr/done.
module tb_ntt_ctrl;

    localparam int PL = 8;

    typedef struct {int a; int b; int tw; int ct; int cyc;} rd_t;
    typedef struct {int a; int b; int cyc;} wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    ntt_ctrl_if bus();

    ntt_ctrl #(.PIPE_LAT(PL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rd_t rdq[$];
    wr_t wrq[$];
    int  ps;
    int  exp_done;
    int  n_rd;
    int  n_wr;
    bit  act = 1'b0;
    int  wr_cnt[256];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", nm, cyc, got, exp);
        end
    endtask

    // Expected pass from the reference loop: for each len, groups of len
    // butterflies spaced 2*len; one zeta per group, counting up (forward)
    // or down (inverse). Issues are back to back, PL idle cycles per gap.
    task automatic build(input bit iv, input int s);
        int t, k, len;
        t   = s + 1;
        k   = iv ? 127 : 1;
        len = iv ? 2 : 128;
        for (int l = 0; l < 7; l++) begin
            for (int st = 0; st < 256; st += 2*len) begin
                for (int jj = st; jj < st + len; jj++) begin
                    rdq.push_back('{jj, jj + len, k, (iv ? 0 : 1), t});
                    wrq.push_back('{jj, jj + len, t + PL});
                    t++;
                end
                k = iv ? k - 1 : k + 1;
            end
            if (l < 6) t += PL;
            len = iv ? len * 2 : len / 2;
        end
        exp_done = t + PL;
    endtask

    task automatic start_pass(input bit iv);
        bus.inv   = iv;
        bus.start = 1'b1;
        ps = cyc + 1;
        build(iv, ps);
        n_rd = 0;
        n_wr = 0;
        for (int i = 0; i < 256; i++) wr_cnt[i] = 0;
        act = 1'b1;
        @(posedge clk); #2;
        bus.start = 1'b0;
        bus.inv   = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (act && n < 1500) begin
            @(negedge clk); #1;
            n++;
        end
        if (act) begin
            chk("done_timeout", 32'(act), 0);
            act = 1'b0;
            rdq.delete();
            wrq.delete();
        end
    endtask

    task automatic pass_checks();
        chk("rd_left", rdq.size(), 0);
        chk("wr_left", wrq.size(), 0);
        chk("rd_count", n_rd, 896);
        chk("wr_count", n_wr, 896);
        for (int i = 0; i < 256; i++)
            chk($sformatf("wr_cover[%0d]", i), wr_cnt[i], 7);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"},      bus.busy, 0);
        chk({tag, "_done"},      bus.done, 0);
        chk({tag, "_ct"},        bus.ct, 0);
        chk({tag, "_rd_valid"},  bus.rd_valid, 0);
        chk({tag, "_rd_addr_a"}, bus.rd_addr_a, 0);
        chk({tag, "_rd_addr_b"}, bus.rd_addr_b, 0);
        chk({tag, "_tw_addr"},   bus.tw_addr, 0);
        chk({tag, "_wr_valid"},  bus.wr_valid, 0);
        chk({tag, "_wr_addr_a"}, bus.wr_addr_a, 0);
        chk({tag, "_wr_addr_b"}, bus.wr_addr_b, 0);
    endtask

    // Monitor
    rd_t re;
    wr_t we;
    always @(negedge clk) begin
        if (!rst) begin
            chk("busy", bus.busy, 32'(act && cyc >= ps + 1 && cyc < exp_done));
            if (bus.rd_valid) begin
                n_rd++;
                if (rdq.size() == 0) begin
                    chk("rd_unexpected", 1, 0);
                end else begin
                    re = rdq.pop_front();
                    chk("rd_cycle",  cyc, re.cyc);
                    chk("rd_addr_a", bus.rd_addr_a, re.a);
                    chk("rd_addr_b", bus.rd_addr_b, re.b);
                    chk("tw_addr",   bus.tw_addr, re.tw);
                    chk("ct",        bus.ct, re.ct);
                end
            end
            if (bus.wr_valid) begin
                n_wr++;
                wr_cnt[bus.wr_addr_a]++;
                wr_cnt[bus.wr_addr_b]++;
                if (wrq.size() == 0) begin
                    chk("wr_unexpected", 1, 0);
                end else begin
                    we = wrq.pop_front();
                    chk("wr_cycle",  cyc, we.cyc);
                    chk("wr_addr_a", bus.wr_addr_a, we.a);
                    chk("wr_addr_b", bus.wr_addr_b, we.b);
                end
            end
            if (bus.done) begin
                if (act) chk("done_cycle", cyc, exp_done);
                else     chk("done_unexpected", 1, 0);
                act = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0;
        bus.inv   = 1'b0;
        rst       = 1'b1;
        repeat (3) @(posedge clk); #2;
        chk_zero("rst");
        rst = 1'b0;
        repeat (2) @(posedge clk); #2;
        chk_zero("idle");

        // Forward pass; a start (with inv=1) 300 cycles in must be ignored.
        start_pass(1'b0);
        repeat (299) @(posedge clk); #2;
        bus.start = 1'b1;
        bus.inv   = 1'b1;
        @(posedge clk); #2;
        bus.start = 1'b0;
        wait_done();
        pass_checks();

        // Inverse pass started in the cycle right after done.
        start_pass(1'b1);
        wait_done();
        pass_checks();

        // Random direction, random idle spacing.
        repeat (3) begin
            repeat ($urandom_range(0, 20)) @(posedge clk);
            #2;
            start_pass(1'($urandom_range(0, 1)));
            wait_done();
            pass_checks();
        end

        // Reset mid-pass drops everything; next start behaves as fresh.
        start_pass(1'b0);
        repeat (500) @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk_zero("midrst");
        rdq.delete();
        wrq.delete();
        act = 1'b0;
        repeat (2) @(posedge clk); #2;
        rst = 1'b0;
        repeat (PL + 2) @(posedge clk); #2;
        chk_zero("postrst");
        start_pass(1'b0);
        wait_done();
        pass_checks();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ntt_ctrl.md
# ntt_ctrl

Sequencer for a full 256-point Kyber NTT or inverse NTT (q = 3329) pass, sitting directly upstream of the butterfly unit. It walks all 7 layers and issues one butterfly per cycle: coefficient-RAM read addresses, twiddle-ROM index and CT/GS mode select. It also delays each pair's addresses to produce write-back strobes aligned with the butterfly outputs. Layer-to-layer read-after-write hazards are removed by inserting a drain gap between layers.

## Interface
- PIPE_LAT, 8: cycles from an rd_valid issue to the matching butterfly E/O being available for write-back (RAM read + butterfly pipeline); legal range 1..31.
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin a pass; sampled only in IDLE
- inv  in  1  0 = forward NTT (CT), 1 = inverse NTT (GS); sampled with start
- busy  out  1  high while a pass is in progress
- done  out  1  one-cycle pulse at end of pass
- ct  out  1  butterfly mode, ~inv latched at start; held for the whole pass
- rd_valid  out  1  rd_addr_a/rd_addr_b/tw_addr valid this cycle
- rd_addr_a  out  8  even-side coefficient address j
- rd_addr_b  out  8  odd-side coefficient address j+len
- tw_addr  out  7  twiddle ROM index k (ROM selects forward/inverse constant table by ct)
- wr_valid  out  1  write E to wr_addr_a and O to wr_addr_b this cycle
- wr_addr_a  out  8  rd_addr_a delayed PIPE_LAT cycles
- wr_addr_b  out  8  rd_addr_b delayed PIPE_LAT cycles

## Operation
- States: IDLE, RUN, GAP, DRAIN, DONE.
- IDLE: start=1 latches inv/ct, clears layer (3 b) and idx (7 b), goes to RUN. start=0 stays IDLE.
- RUN: rd_valid=1 every cycle with addresses for (layer, idx); idx increments.
  - At idx=127 with layer<6: go to GAP.
  - At idx=127 with layer=6: go to DRAIN.
- GAP: rd_valid=0 for exactly PIPE_LAT cycles (gap counter), then layer+1, idx=0, RUN.
- DRAIN: rd_valid=0 for PIPE_LAT cycles until the final wr_valid has occurred, then DONE.
- DONE: done=1 for one cycle, busy=0, return to IDLE.
- start outside IDLE is ignored, and inv is not re-sampled.
- Forward (inv=0):
  - lg = 7−layer, len = 1<<lg.
  - j = ((idx>>lg)<<(lg+1)) | (idx & (len−1)).
  - rd_addr_a = j, rd_addr_b = j+len.
  - tw_addr = (1<<layer) + (idx>>lg), giving k = 1..127.
- Inverse (inv=1):
  - lg = layer+1, len = 1<<lg, same j formula.
  - tw_addr = (128>>layer) − 1 − (idx>>lg), giving k = 127 down to 1.
- All address arithmetic is unsigned, 8 bits. No overflow is possible because j+len ≤ 255.
- Write-back path: a PIPE_LAT-deep shift register of {rd_valid, rd_addr_a, rd_addr_b} drives {wr_valid, wr_addr_a, wr_addr_b}.
- rst at any time, including mid-pass:
  - state = IDLE.
  - All counters and the delay line are cleared, so in-flight writes are discarded.
  - All outputs go to 0.

## Timing
- Reset value of every output: 0.
- All outputs are registered.
- Cycle 0 = edge where start is sampled in IDLE.
  - Cycle 1: busy=1 and the first rd_valid is issued.
- Each layer is 128 consecutive rd_valid cycles, followed by PIPE_LAT idle cycles (GAP, 6 times).
- wr_valid rises exactly PIPE_LAT cycles after its rd_valid.
- The last write of a layer lands in the cycle before the next layer's first issue.
- Last rd_valid is at cycle 896 + 6·PIPE_LAT; last wr_valid is PIPE_LAT cycles later.
- done pulses one cycle after the last wr_valid, with busy=0 in the same cycle.
- Total with PIPE_LAT=8: done at cycle 953.
- A new start is accepted in the cycle after done.

## Structure
- Shared package kyber_pkg holds:
  - constants N=256, LOG_N=8, NTT_LAYERS=7, KYBER_Q=3329;
  - the state enum for ntt_ctrl.
- One sub-module, ntt_wb_delay: a parameterized PIPE_LAT × 17-bit shift register with async active-high reset, clearing all stages.
- Address and twiddle computation stays in ntt_ctrl as a combinational function of (layer, idx, inv), registered at the outputs.

## Test plan
- Forward, first issue: start, inv=0 → cycle 1: rd_addr_a=0, rd_addr_b=128, tw_addr=1, ct=1. Issue 127 gives a=127, b=255.
- Forward, layer-6 start (after 6 gaps): first issue a=0, b=2, tw=64. Final issue a=253, b=255, tw=127.
- Inverse: first issue a=0, b=2, tw=127. Layer 1 first issue a=0, b=4, tw=63. Final issue a=127, b=255, tw=1, ct=0.
- Count/handshake, PIPE_LAT=8:
  - exactly 896 rd_valid and 896 wr_valid;
  - wr addresses equal rd addresses 8 cycles earlier;
  - done a single pulse at cycle 953;
  - start pulsed at cycle 300 has no effect.
- Coverage: every address 0..255 is written exactly 7 times.
- Reset mid-pass: assert rst at cycle 500 → all outputs 0 immediately. After release, the next start reproduces the cycle-1 forward values.
